// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package cpu_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational owner choice: data wins unless fetch has waited out a full streak.
module mem_arb_select #(
  parameter int MAX_D_STREAK = 4,
  parameter int SW           = 3
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [SW-1:0] streak,
  output logic          sel_d
);

  // Fetch is chosen only when data is absent or fetch is owed a turn.
  always_comb begin
    sel_d = 1'b0;
    if (d_req && !(if_req && (streak == SW'(MAX_D_STREAK))))
      sel_d = 1'b1;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares a single-ported memory between fetch and load/store, one transaction at a time.
module unified_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  arb_state_t    state, state_nx;
  owner_t        owner;
  logic [SW-1:0] streak;
  logic          sel_d;
  logic          accept;

  mem_arb_select #(
    .MAX_D_STREAK(MAX_D_STREAK),
    .SW          (SW)
  ) u_select (
    .if_req(if_req),
    .d_req (d_req),
    .streak(streak),
    .sel_d (sel_d)
  );

  // Next state and all outputs; everything is forced low while reset is held.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    busy      = 1'b0;
    if (rst) begin
      busy = (state == WAIT);
      case (state)
        IDLE: begin
          mem_req = if_req | d_req;
          if (sel_d) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
          end else begin
            mem_addr  = if_addr;
            mem_be    = '1;
          end
          if (mem_req && mem_gnt) begin
            accept   = 1'b1;
            if_gnt   = ~sel_d;
            d_gnt    = sel_d;
            state_nx = WAIT;
          end
        end
        WAIT: begin
          // Requests are ignored here; only the response matters.
          if (mem_rvalid) begin
            state_nx = IDLE;
            if (owner == OWN_D) begin
              d_rvalid = 1'b1;
              d_rdata  = mem_rdata;
            end else begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State, owner and fetch-starvation streak; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      owner  <= OWN_IF;
      streak <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner <= sel_d ? OWN_D : OWN_IF;
        if (sel_d && if_req) begin
          if (streak != SW'(MAX_D_STREAK))
            streak <= streak + SW'(1);
        end else begin
          streak <= '0;
        end
      end
    end
  end

endmodule
